// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default sizes for the register file and the address-width helper
package reg_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ZERO_REG = 1;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: register-file bus; two read ports (addr->data,busy), writeback, issue, flush, any_busy
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr, issue_addr;
  logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data;
  logic rd_busy_a, rd_busy_b, wr_en, issue_en, flush, any_busy;
  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
  );
  modport slave (
    input rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
  );
endinterface

// File: rtl/reg_cell.sv
// reg_cell: W-bit negedge register; clk, reset (async high, clears to 0), we, d in, q out
module reg_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q, data_d;
  always_comb data_d = we ? d : data_q;
  always_ff @(negedge clk or posedge reset)
    if (reset) data_q <= '0;
    else data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: negedge register file with busy scoreboard and write-through forwarding; clk, reset (async high), bus (slave)
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic clk,
  input logic reset,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = addr_w(NUM_REGS);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, wr_hit, iss_hit, busy_we;
  logic wr_ok, iss_ok;
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
  endfunction
  // forwarding is gated by reset so outputs read 0 while reset is held
  always_comb begin
    wr_ok = !reset && bus.wr_en && ok(bus.wr_addr);
    iss_ok = bus.issue_en && ok(bus.issue_addr) && !bus.flush;
    wr_hit = '0;
    iss_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = wr_ok && bus.wr_addr == ADDR_W'(i);
      iss_hit[i] = iss_ok && bus.issue_addr == ADDR_W'(i);
    end
    busy_we = wr_hit | iss_hit | {NUM_REGS{bus.flush}};
    bus.rd_data_a = !ok(bus.rd_addr_a) ? '0 :
                    (wr_ok && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : mem_q[bus.rd_addr_a];
    bus.rd_data_b = !ok(bus.rd_addr_b) ? '0 :
                    (wr_ok && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : mem_q[bus.rd_addr_b];
    bus.rd_busy_a = ok(bus.rd_addr_a) && busy_q[bus.rd_addr_a];
    bus.rd_busy_b = ok(bus.rd_addr_b) && busy_q[bus.rd_addr_b];
    bus.any_busy = |busy_q;
  end
  // busy loads the issue hit whenever written: issue beats a same-edge write, flush clears
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    reg_cell #(.W(DATA_W)) u_data (
      .clk(clk), .reset(reset), .we(wr_hit[g]), .d(bus.wr_data), .q(mem_q[g])
    );
    reg_cell #(.W(1)) u_busy (
      .clk(clk), .reset(reset), .we(busy_we[g]), .d(iss_hit[g]), .q(busy_q[g])
    );
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-register storage for the pipelined datapath: NUM_REGS words of DATA_W bits, two combinational read ports and one write port. It has a per-register busy scoreboard for hazard detection, and write-through forwarding. State updates on the falling edge of clk, so writeback occurs mid-cycle and decode reads in the second half.

Parameters:
DATA_W, 32, width of each register
NUM_REGS, 32, number of registers (need not be a power of two)
ZERO_REG, 1, if 1 register 0 is hardwired to zero and never busy
ADDR_W, $clog2(NUM_REGS), address width (localparam, derived)

Ports:
clk  in  1  clock; all state updates on negedge
reset  in  1  asynchronous, active-high
rd_addr_a  in  ADDR_W  read port A address
rd_data_a  out  DATA_W  read port A data
rd_busy_a  out  1  scoreboard busy bit of rd_addr_a
rd_addr_b  in  ADDR_W  read port B address
rd_data_b  out  DATA_W  read port B data
rd_busy_b  out  1  scoreboard busy bit of rd_addr_b
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback register
wr_data  in  DATA_W  writeback data
issue_en  in  1  instruction issued that will write issue_addr
issue_addr  in  ADDR_W  destination being reserved
flush  in  1  pipeline flush: clear all busy bits
any_busy  out  1  OR of all busy bits

Behaviour:
- reset (async, active-high): all registers = 0, all busy bits = 0. Outputs immediately read 0: rd_data_* = 0, rd_busy_* = 0, any_busy = 0. Reset asserted mid-operation discards pending writes/issues at once.
- Write: on negedge clk, if wr_en, wr_addr < NUM_REGS, and not (ZERO_REG && wr_addr == 0), then mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Issue: on negedge clk, if issue_en, issue_addr < NUM_REGS, and not (ZERO_REG && issue_addr == 0), then busy[issue_addr] <= 1.
- Same edge, wr_addr == issue_addr, both enabled: data written; busy ends 1 (new producer wins).
- flush on an edge: all busy bits <= 0. flush overrides issue on the same edge; a concurrent write still updates data.
- Reads are combinational:
  - rd_data_x = wr_data when wr_en and wr_addr == rd_addr_x and the address is writable (write-through forward).
  - Otherwise rd_data_x = mem[rd_addr_x].
  - Out-of-range address, or address 0 with ZERO_REG = 1, reads 0.
- rd_busy_x reflects registered busy state only, with no forwarding. Out-of-range address reads 0.
- Latency: write visible via forwarding in the same cycle; stored from the next negedge. Busy set/clear visible after the negedge on which it occurs.
- Both read ports may address the same register; no conflict.

Decomposition:
- Package reg_file_pkg: default DATA_W/NUM_REGS constants, address-width function, ZERO_REG default.
- Sub-module reg_cell: DATA_W-bit negedge register with write enable and async active-high reset to 0. Instantiated per register via generate. The busy bits are 1-bit reg_cell instances.

Test Plan:
- Reset: assert reset mid-cycle after writing r5 = 0x1234 -> rd_data_a (r5) = 0 immediately, any_busy = 0.
- Write/read: wr_en, wr_addr = 3, wr_data = 0xDEADBEEF -> forwarded same cycle on rd_data_a (r3); after negedge, wr_en = 0 -> still 0xDEADBEEF on both ports.
- Zero register: write r0 = 0xFFFFFFFF with ZERO_REG = 1 -> rd_data_a (r0) = 0. Issue r0 -> rd_busy_a = 0.
- Scoreboard: issue r7 -> after negedge rd_busy_b (r7) = 1, any_busy = 1. Write r7 = 0x55 -> busy clears after negedge, data 0x55.
- Collision: same edge issue r9 and write r9 = 0xAA -> r9 = 0xAA and busy = 1. Then flush together with issue r10 -> all busy = 0, any_busy = 0.
- NUM_REGS = 24: write addr 30 = 0x77 -> no register changes, rd_data (addr 30) = 0. Issue 30 -> any_busy stays 0.
